// File: rtl/pulse_generator.sv
// Converts a one-clock start request into a pulse of programmable delay,
// width and polarity; all outputs are registered.
module pulse_generator #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 edge_generate,
  input  logic [CNT_WIDTH-1:0] delay,
  input  logic [CNT_WIDTH-1:0] width,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE} state_t;

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt, cnt_d;
  logic [CNT_WIDTH-1:0] width_q, width_q_d;
  logic                 pol, pol_d;
  logic                 out_d, busy_d, done_d;

  // Active-phase reload value: a width of 0 behaves like 1.
  function automatic logic [CNT_WIDTH-1:0] len_m1(
    input logic [CNT_WIDTH-1:0] w
  );
    return (w == '0) ? '0 : w - 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      width_q <= '0;
      pol     <= 1'b0;
      out     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      width_q <= width_q_d;
      pol     <= pol_d;
      out     <= out_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_d = (delay == '0) ? ACTIVE : DELAY;
      end
      DELAY: begin
        if (abort)
          state_d = IDLE;
        else if (cnt == '0)
          state_d = ACTIVE;
      end
      ACTIVE: begin
        if (abort || cnt == '0)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt;
    width_q_d = width_q;
    pol_d     = pol;
    out_d     = out;
    busy_d    = busy;
    done_d    = 1'b0;
    unique case (state)
      IDLE: begin
        out_d  = ~edge_generate;
        busy_d = 1'b0;
        if (start) begin
          pol_d     = edge_generate;
          width_q_d = width;
          busy_d    = 1'b1;
          if (delay == '0) begin
            out_d = edge_generate;
            cnt_d = len_m1(width);
          end else begin
            cnt_d = delay - 1'b1;
          end
        end
      end
      DELAY: begin
        if (abort) begin
          out_d  = ~pol;
          busy_d = 1'b0;
          cnt_d  = '0;
        end else if (cnt == '0) begin
          out_d = pol;
          cnt_d = len_m1(width_q);
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      ACTIVE: begin
        if (abort) begin
          out_d  = ~pol;
          busy_d = 1'b0;
          cnt_d  = '0;
        end else if (cnt == '0) begin
          out_d  = ~pol;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: begin
        out_d  = 1'b0;
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: directed scenarios plus random traffic,
// all checked against a schedule-based reference model.
module tb_pulse_generator;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         edge_generate = 1'b0;
  logic [W-1:0] delay = '0;
  logic [W-1:0] width = '0;
  logic         out, busy, done;

  int tests = 0;
  int fails = 0;

  pulse_generator #(.CNT_WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .edge_generate(edge_generate),
    .delay(delay),
    .width(width),
    .out(out),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Model: an accepted job at edge t0 is active on edges [t0+d, t0+d+w)
  // and completes (done) on edge t0+d+w.
  logic   m_run = 1'b0;
  logic   m_pol = 1'b0;
  logic   m_out = 1'b0;
  logic   m_busy = 1'b0;
  logic   m_done = 1'b0;
  longint cyc = 0;
  longint m_t0 = 0;
  longint m_d = 0;
  longint m_w = 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run  = 1'b0;
      m_out  = 1'b0;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      cyc++;
      m_done = 1'b0;
      if (m_run && abort) begin
        m_run = 1'b0;
        m_out = !m_pol;
      end else if (m_run) begin
        if (cyc - m_t0 == m_d + m_w) begin
          m_run  = 1'b0;
          m_done = 1'b1;
          m_out  = !m_pol;
        end else begin
          m_out = (cyc - m_t0 >= m_d) ? m_pol : !m_pol;
        end
      end else if (start) begin
        m_run = 1'b1;
        m_t0  = cyc;
        m_pol = edge_generate;
        m_d   = longint'(delay);
        m_w   = (width == '0) ? 1 : longint'(width);
        m_out = (m_d == 0) ? m_pol : !m_pol;
      end else begin
        m_out = !edge_generate;
      end
      m_busy = m_run;
    end
  end

  task automatic test_reset();
    edge_generate = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({out, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_vals got=%b%b%b want=000", out, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({out, busy, done} !== 3'b100) begin
      fails++;
      $display("FAIL reset_idle got=%b%b%b want=100", out, busy, done);
    end
  endtask

  task automatic test_basic();
    int first = -1;
    int hi = 0;
    int dn = 0;
    int bz = 0;
    edge_generate = 1'b1;
    @(negedge clk);
    delay = 3;
    width = 2;
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if ({out, busy, done} !== {m_out, m_busy, m_done}) begin
        fails++;
        $display("FAIL basic k=%0d got=%b%b%b want=%b%b%b",
                 k, out, busy, done, m_out, m_busy, m_done);
      end
      if (out && first < 0) first = k;
      if (out) hi++;
      if (done) dn++;
      if (busy) bz++;
    end
    tests++;
    if (first != 3 || hi != 2 || dn != 1 || bz != 5) begin
      fails++;
      $display("FAIL basic_shape lead=%0d hi=%0d done=%0d busy=%0d want=3 2 1 5",
               first, hi, dn, bz);
    end
  endtask

  task automatic test_zero();
    int first = -1;
    int lo = 0;
    int dk = -1;
    edge_generate = 1'b0;
    @(negedge clk);
    delay = 0;
    width = 0;
    start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if ({out, busy, done} !== {m_out, m_busy, m_done}) begin
        fails++;
        $display("FAIL zero k=%0d got=%b%b%b want=%b%b%b",
                 k, out, busy, done, m_out, m_busy, m_done);
      end
      if (!out && first < 0) first = k;
      if (!out) lo++;
      if (done) dk = k;
    end
    tests++;
    if (first != 0 || lo != 1 || dk != 1) begin
      fails++;
      $display("FAIL zero_shape lead=%0d lo=%0d donek=%0d want=0 1 1",
               first, lo, dk);
    end
  endtask

  task automatic test_back_to_back();
    int leads = 0;
    logic prev = 1'b0;
    edge_generate = 1'b1;
    @(negedge clk);
    delay = 5;
    width = 4;
    start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start = (k < 3);
      if (k == 1) begin
        delay = 7;
        width = 7;
      end
      tests++;
      if ({out, busy, done} !== {m_out, m_busy, m_done}) begin
        fails++;
        $display("FAIL b2b k=%0d got=%b%b%b want=%b%b%b",
                 k, out, busy, done, m_out, m_busy, m_done);
      end
      if (out && !prev) leads++;
      prev = out;
      if (done && leads == 1) begin
        start = 1'b1;
        delay = 2;
        width = 1;
      end
    end
    start = 1'b0;
    tests++;
    if (leads != 2) begin
      fails++;
      $display("FAIL b2b_leads got=%0d want=2", leads);
    end
  endtask

  task automatic test_abort();
    int dn = 0;
    int hi = 0;
    edge_generate = 1'b1;
    @(negedge clk);
    delay = 1;
    width = 10;
    start = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == 3);
      tests++;
      if ({out, busy, done} !== {m_out, m_busy, m_done}) begin
        fails++;
        $display("FAIL abort_act k=%0d got=%b%b%b want=%b%b%b",
                 k, out, busy, done, m_out, m_busy, m_done);
      end
      if (done) dn++;
      if (out) hi++;
    end
    tests++;
    if (dn != 0 || hi != 3) begin
      fails++;
      $display("FAIL abort_act_shape done=%0d hi=%0d want=0 3", dn, hi);
    end
    delay = 3;
    width = 2;
    start = 1'b1;
    hi = 0;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (k == 2);
      tests++;
      if ({out, busy, done} !== {m_out, m_busy, m_done}) begin
        fails++;
        $display("FAIL abort_dly k=%0d got=%b%b%b want=%b%b%b",
                 k, out, busy, done, m_out, m_busy, m_done);
      end
      if (out) hi++;
      if (done) dn++;
    end
    tests++;
    if (hi != 0 || dn != 0) begin
      fails++;
      $display("FAIL abort_dly_shape hi=%0d done=%0d want=0 0", hi, dn);
    end
  endtask

  task automatic test_async_reset();
    int dn = 0;
    edge_generate = 1'b0;
    delay = 4;
    width = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({out, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL async_delay got=%b%b%b want=000", out, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    edge_generate = 1'b1;
    delay = 0;
    width = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({out, busy, done} !== 3'b110) begin
      fails++;
      $display("FAIL async_restart got=%b%b%b want=110", out, busy, done);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({out, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL async_active got=%b%b%b want=000", out, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    delay = 1;
    width = 2;
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if ({out, busy, done} !== {m_out, m_busy, m_done}) begin
        fails++;
        $display("FAIL async_after k=%0d got=%b%b%b want=%b%b%b",
                 k, out, busy, done, m_out, m_busy, m_done);
      end
      if (done) dn++;
    end
    tests++;
    if (dn != 1) begin
      fails++;
      $display("FAIL async_after_done got=%0d want=1", dn);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      tests++;
      if ({out, busy, done} !== {m_out, m_busy, m_done}) begin
        fails++;
        $display("FAIL random k=%0d got=%b%b%b want=%b%b%b",
                 k, out, busy, done, m_out, m_busy, m_done);
      end
      start         = ($urandom % 4) == 0;
      abort         = ($urandom % 16) == 0;
      edge_generate = $urandom % 2;
      delay         = W'($urandom % 6);
      width         = W'($urandom % 5);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_max_delay();
    int first = -1;
    int hi = 0;
    repeat (8) @(negedge clk);
    edge_generate = 1'b1;
    @(negedge clk);
    delay = 16'hFFFF;
    width = 1;
    start = 1'b1;
    for (int k = 0; k < 65540; k++) begin
      @(negedge clk);
      start = 1'b0;
      tests++;
      if ({out, busy, done} !== {m_out, m_busy, m_done}) begin
        fails++;
        $display("FAIL maxdly k=%0d got=%b%b%b want=%b%b%b",
                 k, out, busy, done, m_out, m_busy, m_done);
      end
      if (out && first < 0) first = k;
      if (out) hi++;
    end
    tests++;
    if (first != 65535 || hi != 1) begin
      fails++;
      $display("FAIL maxdly_shape lead=%0d hi=%0d want=65535 1", first, hi);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    test_max_delay();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
